mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 55 +++++
 rtl/mem_lsu_if.sv | 30 +++
 rtl/load_ext.sv | 33 +++
 rtl/mem_lsu.sv | 143 ++++++++++++++
 tb/tb_mem_lsu.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared op codes, exception codes and bus size encodings
// for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam logic [7:0] OP_LB  = 8'h90;
  localparam logic [7:0] OP_LBU = 8'h91;
  localparam logic [7:0] OP_LH  = 8'h92;
  localparam logic [7:0] OP_LHU = 8'h93;
  localparam logic [7:0] OP_LW  = 8'h94;
  localparam logic [7:0] OP_SB  = 8'h98;
  localparam logic [7:0] OP_SH  = 8'h99;
  localparam logic [7:0] OP_SW  = 8'h9A;

  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic  mem;
    logic  ld;
    logic  st;
    size_e size;
  } op_info_t;

  function automatic op_info_t decode_op(
    input logic [7:0] op
  );
    op_info_t r;
    r = '{mem: 1'b0, ld: 1'b0, st: 1'b0,
          size: SZ_WORD};
    unique case (1'b1)
      (op == OP_LB), (op == OP_LBU):
        r = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
      (op == OP_LH), (op == OP_LHU):
        r = '{1'b1, 1'b1, 1'b0, SZ_HALF};
      (op == OP_LW):
        r = '{1'b1, 1'b1, 1'b0, SZ_WORD};
      (op == OP_SB):
        r = '{1'b1, 1'b0, 1'b1, SZ_BYTE};
      (op == OP_SH):
        r = '{1'b1, 1'b0, 1'b1, SZ_HALF};
      (op == OP_SW):
        r = '{1'b1, 1'b0, 1'b1, SZ_WORD};
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus request/response bundle between the LSU
// and the memory side.
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size,
    output data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size,
    input  data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok,
    output data_rdata
  );

endinterface

// File: rtl/load_ext.sv
// Selects the addressed byte/half of a loaded word
// and sign- or zero-extends it.
module load_ext
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word_i[{addr_i, 3'b000} +: 8];
  assign half_s = word_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = word_i;
    unique case (1'b1)
      (op_i == OP_LB):
        data_o = {{24{byte_s[7]}}, byte_s};
      (op_i == OP_LBU):
        data_o = {24'b0, byte_s};
      (op_i == OP_LH):
        data_o = {{16{half_s[15]}}, half_s};
      (op_i == OP_LHU):
        data_o = {16'b0, half_s};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one outstanding access
// on a split addr_ok/data_ok bus, with flush draining.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wa,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wd,
  input  logic        mem_mreg,
  input  logic [31:0] mem_din,
  input  logic [4:0]  mem_exccode,
  input  logic        flush,
  input  logic        stall_wb,
  mem_lsu_if.master   bus,
  output logic [4:0]  wb_wa,
  output logic        wb_wreg,
  output logic [31:0] wb_wd,
  output logic [4:0]  mem_exccode_o,
  output logic        stall_req_mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  op_info_t    info;
  logic        misal;
  logic        exc_in;
  logic        launch;
  logic [31:0] ld_data;

  assign info   = decode_op(mem_aluop);
  assign exc_in = (mem_exccode != EXC_NONE);
  assign misal  = info.mem &&
    ((info.size == SZ_HALF && mem_wd[0]) ||
     (info.size == SZ_WORD && mem_wd[1:0] != 2'b00));
  // launch is gated by reset so stall drops with it
  assign launch = (state_q == S_IDLE) && info.mem &&
    !misal && !exc_in && !flush && cpu_rst_n;

  load_ext u_ext (
    .op_i   (mem_aluop),
    .addr_i (mem_wd[1:0]),
    .word_i (rdata_q),
    .data_o (ld_data)
  );

  assign bus.data_req  = (state_q == S_REQ);
  assign bus.data_wr   = info.st;
  assign bus.data_size = info.size;
  assign bus.data_addr = mem_wd;

  always_comb begin
    bus.data_wstrb = 4'b0000;
    bus.data_wdata = mem_din;
    if (info.st) begin
      unique case (info.size)
        SZ_BYTE: begin
          bus.data_wstrb = 4'b0001 << mem_wd[1:0];
          bus.data_wdata = {4{mem_din[7:0]}};
        end
        SZ_HALF: begin
          bus.data_wstrb = 4'b0011 << mem_wd[1:0];
          bus.data_wdata = {2{mem_din[15:0]}};
        end
        default: bus.data_wstrb = 4'hF;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    stall_req_mem = 1'b0;
    wb_wa         = mem_wa;
    wb_wreg       = mem_wreg;
    wb_wd         = mem_wd;
    mem_exccode_o = mem_exccode;
    if (misal) begin
      mem_exccode_o = info.ld ? EXC_ADEL : EXC_ADES;
    end
    unique case (state_q)
      S_IDLE: begin
        if (info.mem) wb_wreg = 1'b0;
        if (launch) begin
          state_d       = S_REQ;
          stall_req_mem = 1'b1;
        end
      end
      S_REQ: begin
        stall_req_mem = 1'b1;
        wb_wreg       = 1'b0;
        // an accepted request must still be drained
        if (bus.data_addr_ok) begin
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_req_mem = 1'b1;
        wb_wreg       = 1'b0;
        if (bus.data_data_ok) begin
          rdata_d = bus.data_rdata;
          state_d = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (info.ld) begin
          wb_wreg = mem_wreg && mem_mreg;
          wb_wd   = ld_data;
        end else begin
          wb_wreg = 1'b0;
        end
        if (!stall_wb) state_d = S_IDLE;
      end
      S_DRAIN: begin
        wb_wreg = 1'b0;
        if (bus.data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against
// an arithmetic reference of load/store behaviour.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  aluop = 8'h00;
  logic [4:0]  wa = 5'd0;
  logic        wreg = 1'b0;
  logic [31:0] wd = 32'd0;
  logic        mreg = 1'b0;
  logic [31:0] din = 32'd0;
  logic [4:0]  exc = EXC_NONE;
  logic        flush = 1'b0;
  logic        stall_wb = 1'b0;
  logic [4:0]  wb_wa;
  logic        wb_wreg;
  logic [31:0] wb_wd;
  logic [4:0]  exc_o;
  logic        stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_lsu_if bus();

  mem_lsu dut (
    .cpu_clk_50M   (clk),
    .cpu_rst_n     (rst_n),
    .mem_aluop     (aluop),
    .mem_wa        (wa),
    .mem_wreg      (wreg),
    .mem_wd        (wd),
    .mem_mreg      (mreg),
    .mem_din       (din),
    .mem_exccode   (exc),
    .flush         (flush),
    .stall_wb      (stall_wb),
    .bus           (bus),
    .wb_wa         (wb_wa),
    .wb_wreg       (wb_wreg),
    .wb_wd         (wb_wd),
    .mem_exccode_o (exc_o),
    .stall_req_mem (stall)
  );

  function automatic bit is_ld(input logic [7:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH,
                      OP_LHU, OP_LW};
  endfunction

  function automatic bit is_mem(input logic [7:0] op);
    return is_ld(op) || (op inside {OP_SB, OP_SH, OP_SW});
  endfunction

  function automatic int unsigned nbytes(
    input logic [7:0] op
  );
    if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [7:0] op, input logic [31:0] a,
    input logic [31:0] w
  );
    int unsigned sh, b, h;
    sh = (a % 4) * 8;
    b  = (w >> sh) % 256;
    h  = (w >> sh) % 65536;
    case (op)
      OP_LB:   return b >= 128 ? b + 32'hFFFFFF00 : b;
      OP_LBU:  return b;
      OP_LH:   return h >= 32768 ? h + 32'hFFFF0000 : h;
      OP_LHU:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(
    input logic [7:0] op, input logic [31:0] a
  );
    int unsigned n;
    if (is_ld(op)) return 4'd0;
    n = nbytes(op);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(
    input logic [7:0] op, input logic [31:0] d
  );
    if (nbytes(op) == 1) return (d % 256) * 32'h01010101;
    if (nbytes(op) == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  task automatic run_mem(
    input logic [7:0] op, input logic [31:0] addr,
    input logic [31:0] d, input logic [31:0] rd,
    input int ad, input int dd, input int hold,
    input logic we, input string tag
  );
    int acnt = 0, dcnt = 0, stc = 0, rqc = 0;
    bit acc = 0, fin = 0;
    logic [31:0] c_addr = 0, c_wdata = 0;
    logic [3:0]  c_strb = 0;
    logic [1:0]  c_size = 0;
    logic        c_wr = 0;
    logic [4:0]  twa;
    logic        ewreg;
    logic [31:0] ewd;
    twa = 5'($urandom);
    @(negedge clk);
    aluop = op; wd = addr; din = d; wa = twa;
    wreg = we; mreg = is_ld(op); exc = EXC_NONE;
    flush = 0; stall_wb = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("FAIL %s launch_stall got %b want 1",
               tag, stall);
    end
    for (int c = 0; c < 64; c++) begin
      bus.data_addr_ok = 0;
      bus.data_data_ok = 0;
      bus.data_rdata = $urandom;
      if (stall !== 1'b1 && bus.data_req !== 1'b1) begin
        fin = 1;
        break;
      end
      if (stall === 1'b1) stc++;
      if (bus.data_req === 1'b1) begin
        rqc++;
        if (acnt == ad) begin
          bus.data_addr_ok = 1; acc = 1;
          c_addr = bus.data_addr;
          c_wdata = bus.data_wdata;
          c_strb = bus.data_wstrb;
          c_size = bus.data_size;
          c_wr = bus.data_wr;
        end else acnt++;
      end else if (acc) begin
        if (dcnt == dd) begin
          bus.data_data_ok = 1;
          bus.data_rdata = rd;
        end else dcnt++;
      end
      @(negedge clk); #1;
    end
    tests++;
    if (!fin || !acc) begin
      fails++;
      $display("FAIL %s timeout fin=%0d acc=%0d",
               tag, fin, acc);
      return;
    end
    tests++;
    if (stc != ad + dd + 3) begin
      fails++;
      $display("FAIL %s stall_cycles got %0d want %0d",
               tag, stc, ad + dd + 3);
    end
    tests++;
    if (rqc != ad + 1) begin
      fails++;
      $display("FAIL %s req_cycles got %0d want %0d",
               tag, rqc, ad + 1);
    end
    tests++;
    if (c_addr !== addr || c_wr !== !is_ld(op) ||
        c_size !== 2'(nbytes(op) / 2)) begin
      fails++;
      $display("FAIL %s bus_req got a=%h wr=%b sz=%0d",
               tag, c_addr, c_wr, c_size);
    end
    tests++;
    if (c_strb !== ref_strb(op, addr)) begin
      fails++;
      $display("FAIL %s wstrb got %b want %b",
               tag, c_strb, ref_strb(op, addr));
    end
    if (!is_ld(op)) begin
      tests++;
      if (c_wdata !== ref_wdata(op, d)) begin
        fails++;
        $display("FAIL %s wdata got %h want %h",
                 tag, c_wdata, ref_wdata(op, d));
      end
    end
    ewreg = is_ld(op) ? we : 1'b0;
    ewd = is_ld(op) ? ref_load(op, addr, rd) : addr;
    for (int h = 0; h <= hold; h++) begin
      if (h == 0 && hold > 0) stall_wb = 1;
      if (h == hold) stall_wb = 0;
      tests++;
      if (wb_wreg !== ewreg || wb_wa !== twa ||
          stall !== 1'b0 || exc_o !== EXC_NONE) begin
        fails++;
        $display("FAIL %s done_ctl h=%0d wreg=%b wa=%0d st=%b",
                 tag, h, wb_wreg, wb_wa, stall);
      end
      if (is_ld(op)) begin
        tests++;
        if (wb_wd !== ewd) begin
          fails++;
          $display("FAIL %s wb_wd h=%0d got %h want %h",
                   tag, h, wb_wd, ewd);
        end
      end
      if (h < hold) begin
        @(negedge clk);
        bus.data_rdata = $urandom;
        #1;
      end
    end
  endtask

  task automatic go_nop();
    @(negedge clk);
    aluop = 8'h00; exc = EXC_NONE; flush = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; aluop = 8'h00; wa = 5'd7;
    wreg = 1; wd = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (bus.data_req !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl req=%b stall=%b",
               bus.data_req, stall);
    end
    tests++;
    if (wb_wd !== 32'h1234_5678 || wb_wa !== 5'd7 ||
        wb_wreg !== 1'b1) begin
      fails++;
      $display("FAIL reset_pass wd=%h wa=%0d wreg=%b",
               wb_wd, wb_wa, wb_wreg);
    end
    aluop = OP_LW; wd = 32'h100; #1;
    tests++;
    if (stall !== 1'b0 || bus.data_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_lw stall=%b want 0", stall);
    end
    aluop = 8'h00;
    rst_n = 1;
  endtask

  task automatic test_passthrough();
    logic [7:0] op;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      do op = 8'($urandom); while (is_mem(op));
      aluop = op; wa = 5'($urandom);
      wreg = 1'($urandom); wd = $urandom;
      exc = (i % 2) ? 5'($urandom) : EXC_NONE;
      #1;
      tests++;
      if (wb_wa !== wa || wb_wreg !== wreg ||
          wb_wd !== wd || exc_o !== exc ||
          stall !== 1'b0 || bus.data_req !== 1'b0) begin
        fails++;
        $display("FAIL pass op=%h wd=%h got %h st=%b",
                 op, wd, wb_wd, stall);
      end
    end
    exc = EXC_NONE;
  endtask

  task automatic test_misalign();
    logic [7:0]  ops [4] = '{OP_LW, OP_SW, OP_LH, OP_SH};
    logic [31:0] ads [4] = '{32'h101, 32'h102,
                             32'h103, 32'h101};
    logic [4:0]  want;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      aluop = ops[i]; wd = ads[i]; wreg = 1;
      exc = EXC_NONE;
      #1;
      want = is_ld(ops[i]) ? 5'h04 : 5'h05;
      for (int c = 0; c < 2; c++) begin
        tests++;
        if (exc_o !== want || stall !== 1'b0 ||
            bus.data_req !== 1'b0 || wb_wreg !== 1'b0) begin
          fails++;
          $display("FAIL misal op=%h exc=%h want %h st=%b",
                   ops[i], exc_o, want, stall);
        end
        @(negedge clk); #1;
      end
    end
    go_nop();
  endtask

  task automatic test_exc_suppress();
    @(negedge clk);
    aluop = OP_LW; wd = 32'h200; exc = 5'h0C; wreg = 1;
    #1;
    for (int c = 0; c < 2; c++) begin
      tests++;
      if (exc_o !== 5'h0C || stall !== 1'b0 ||
          bus.data_req !== 1'b0) begin
        fails++;
        $display("FAIL exc_sup exc=%h st=%b req=%b",
                 exc_o, stall, bus.data_req);
      end
      @(negedge clk); #1;
    end
    go_nop();
  endtask

  task automatic test_flush();
    @(negedge clk);
    aluop = OP_LW; wd = 32'h200; wreg = 1; mreg = 1;
    #1;
    @(negedge clk); #1;
    tests++;
    if (bus.data_req !== 1'b1) begin
      fails++;
      $display("FAIL flush_req got %b want 1", bus.data_req);
    end
    bus.data_addr_ok = 1;
    @(negedge clk); #1;
    bus.data_addr_ok = 0;
    flush = 1;
    @(negedge clk);
    flush = 0; aluop = 8'h00; wreg = 1;
    #1;
    tests++;
    if (stall !== 1'b0 || wb_wreg !== 1'b0 ||
        bus.data_req !== 1'b0) begin
      fails++;
      $display("FAIL drain st=%b wreg=%b req=%b",
               stall, wb_wreg, bus.data_req);
    end
    @(negedge clk); #1;
    bus.data_data_ok = 1; bus.data_rdata = 32'h1111_1111;
    @(negedge clk); #1;
    bus.data_data_ok = 0;
    tests++;
    if (wb_wreg !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL drain_exit wreg=%b st=%b",
               wb_wreg, stall);
    end
    run_mem(OP_LW, 32'h204, 0, 32'hCAFE_F00D,
            1, 1, 0, 1, "after_drain");
    @(negedge clk);
    aluop = OP_SW; wd = 32'h300; #1;
    @(negedge clk); flush = 1; #1;
    @(negedge clk); flush = 0; aluop = 8'h00; #1;
    tests++;
    if (bus.data_req !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_req_wd req=%b st=%b",
               bus.data_req, stall);
    end
    go_nop();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    aluop = OP_LW; wd = 32'h300; wreg = 1;
    #1;
    @(negedge clk); #1;
    rst_n = 0; #1;
    tests++;
    if (bus.data_req !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid req=%b st=%b",
               bus.data_req, stall);
    end
    @(negedge clk);
    aluop = 8'h00; rst_n = 1;
    #1;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (bus.data_req !== 1'b0 || stall !== 1'b0) begin
        fails++;
        $display("FAIL rst_after c=%0d req=%b", c,
                 bus.data_req);
      end
      @(negedge clk); #1;
    end
    run_mem(OP_LBU, 32'h305, 0, 32'h0000_7F00,
            0, 2, 0, 1, "after_rst");
  endtask

  task automatic test_random();
    logic [7:0] ops [8] = '{OP_LB, OP_LBU, OP_LH,
      OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    logic [7:0]  op;
    logic [31:0] a;
    int unsigned n;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      n = nbytes(op);
      a = ($urandom & 32'hFFFF_FFFC) +
          n * $urandom_range(0, 4 / n - 1);
      run_mem(op, a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom), "rand");
    end
    go_nop();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    run_mem(OP_LW, 32'h100, 0, 32'hDEAD_BEEF,
            0, 0, 0, 1, "lw_basic");
    run_mem(OP_LB, 32'h103, 0, 32'h8011_2233,
            0, 1, 0, 1, "lb");
    run_mem(OP_LBU, 32'h103, 0, 32'h8011_2233,
            1, 0, 0, 1, "lbu");
    run_mem(OP_SH, 32'h102, 32'h0000_ABCD, 0,
            0, 0, 1, 1, "sh");
    test_misalign();
    test_exc_suppress();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
